// File: rtl/ix_sched.sv
// ix_sched: in-order dual-issue scheduler (scoreboard, in-flight count,
// serialization FSM). Optional perf counters: IX_SCHED_PERF_EN.
module ix_sched #(
   parameter int REG_ABITS = 5,
   parameter int CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pipe_flush,
   input  logic                 dec0_valid,
   input  logic [REG_ABITS-1:0] dec0_rd,
   input  logic [REG_ABITS-1:0] dec0_rs1,
   input  logic [REG_ABITS-1:0] dec0_rs2,
   input  logic                 dec0_rd_en,
   input  logic                 dec0_rs1_en,
   input  logic                 dec0_rs2_en,
   input  logic [1:0]           dec0_unit,
   input  logic                 dec0_serialize,
   input  logic                 dec1_valid,
   input  logic [REG_ABITS-1:0] dec1_rd,
   input  logic [REG_ABITS-1:0] dec1_rs1,
   input  logic [REG_ABITS-1:0] dec1_rs2,
   input  logic                 dec1_rd_en,
   input  logic                 dec1_rs1_en,
   input  logic                 dec1_rs2_en,
   input  logic [1:0]           dec1_unit,
   input  logic                 dec1_serialize,
   output logic                 dec0_ready,
   output logic                 dec1_ready,
   output logic                 ix0_valid,
   input  logic                 ix0_ready,
   output logic                 ix1_valid,
   input  logic                 ix1_ready,
   input  logic                 wb0_valid,
   input  logic [REG_ABITS-1:0] wb0_rd,
   input  logic                 wb0_rd_en,
   input  logic                 wb1_valid,
   input  logic [REG_ABITS-1:0] wb1_rd,
   input  logic                 wb1_rd_en,
   output logic                 sched_busy
`ifdef IX_SCHED_PERF_EN
  ,output logic [31:0]          perf_dual,
   output logic [31:0]          perf_single,
   output logic [31:0]          perf_stall
`endif
);

   localparam int NREG = 1 << REG_ABITS;
   localparam int CW2  = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_DUAL = CNT_MAX - CNT_W'(2);
   localparam logic [1:0] U_ALU = 2'd0;
   localparam logic [1:0] U_BR  = 2'd1;

   typedef enum logic {RUN, SOLO} state_t;

   state_t            state, state_nx;
   logic [NREG-1:0]   sb, sb_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [CW2-1:0]    up, dn;
   logic              act, haz0, haz1, dep;
   logic              ok0, ok1, fire0, fire1;

   function automatic logic reg_busy(
      input logic                 en,
      input logic [REG_ABITS-1:0] r,
      input logic [NREG-1:0]      s
   );
      return en && (r != '0) && s[r];
   endfunction

   assign act = rst_n & ~pipe_flush;

   assign haz0 = reg_busy(dec0_rs1_en, dec0_rs1, sb)
               | reg_busy(dec0_rs2_en, dec0_rs2, sb)
               | reg_busy(dec0_rd_en,  dec0_rd,  sb);

   assign haz1 = reg_busy(dec1_rs1_en, dec1_rs1, sb)
               | reg_busy(dec1_rs2_en, dec1_rs2, sb)
               | reg_busy(dec1_rd_en,  dec1_rd,  sb);

   assign dep = dec0_rd_en & (dec0_rd != '0)
              & ((dec1_rs1_en & (dec1_rs1 == dec0_rd))
               | (dec1_rs2_en & (dec1_rs2 == dec0_rd))
               | (dec1_rd_en  & (dec1_rd  == dec0_rd)));

   // Issue decision for both slots; dec1 only pairs behind a firing dec0
   always_comb begin
      ok0 = 1'b0;
      ok1 = 1'b0;
      ok0 = act & dec0_valid & ~haz0
          & (cnt != CNT_MAX)
          & (state == RUN)
          & (~dec0_serialize | (cnt == '0));
      ok1 = ok0 & ix0_ready & dec1_valid & ~haz1
          & (cnt <= CNT_DUAL)
          & ((dec1_unit == U_ALU) | (dec1_unit == U_BR))
          & ~dec0_serialize & ~dec1_serialize
          & (dec0_unit != U_BR)
          & ~dep;
   end

   assign fire0      = ok0 & ix0_ready;
   assign fire1      = ok1 & ix1_ready;
   assign ix0_valid  = ok0;
   assign ix1_valid  = ok1;
   assign dec0_ready = fire0;
   assign dec1_ready = fire1;
   assign sched_busy = act & ((state != RUN) | (cnt != '0));

   // Scoreboard update: completions clear, new issues set (set wins)
   always_comb begin
      sb_nx = sb;
      if (wb0_valid && wb0_rd_en) sb_nx[wb0_rd] = 1'b0;
      if (wb1_valid && wb1_rd_en) sb_nx[wb1_rd] = 1'b0;
      if (fire0 && dec0_rd_en && dec0_rd != '0) sb_nx[dec0_rd] = 1'b1;
      if (fire1 && dec1_rd_en && dec1_rd != '0) sb_nx[dec1_rd] = 1'b1;
   end

   // In-flight count, saturating at zero on stray completions
   always_comb begin
      up     = CW2'(cnt) + CW2'(fire0) + CW2'(fire1);
      dn     = CW2'(wb0_valid) + CW2'(wb1_valid);
      cnt_nx = '0;
      if (up > dn) cnt_nx = CNT_W'(up - dn);
   end

   // Serialization FSM next state: SOLO drains the machine
   always_comb begin
      state_nx = state;
      unique case (state)
         RUN:     if (fire0 && dec0_serialize) state_nx = SOLO;
         SOLO:    if (cnt_nx == '0) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   // Tracking state registers; flush wipes them synchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb    <= '0;
         cnt   <= '0;
         state <= RUN;
      end else if (pipe_flush) begin
         sb    <= '0;
         cnt   <= '0;
         state <= RUN;
      end else begin
         sb    <= sb_nx;
         cnt   <= cnt_nx;
         state <= state_nx;
      end
   end

`ifdef IX_SCHED_PERF_EN
   // Issue-rate counters, kept across flushes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_dual   <= '0;
         perf_single <= '0;
         perf_stall  <= '0;
      end else begin
         if (fire0 && fire1)      perf_dual   <= perf_dual + 32'd1;
         if (fire0 && !fire1)     perf_single <= perf_single + 32'd1;
         if (dec0_valid && !fire0) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: doc/ix_sched.md
Name: ix_sched

Overview:
- In-order dual-issue scheduler between the 2-read decode instruction queue and the two issue pipes.
- Each cycle it decides whether to issue 0, 1 or 2 instructions: dec0 (older) to pipe0, dec1 (younger) to pipe1.
- Decision uses a register scoreboard, an in-flight counter and a serialization state machine.
- Drives the queue read-ready strobes. Operates on pre-extracted decode fields only, not on full bundles.

Parameters:
REG_ABITS, 5, register index width (2^REG_ABITS scoreboard bits; x0 never tracked)
CNT_W, 4, in-flight counter width; issue stalls at 2^CNT_W-1 in flight

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pipe_flush  input  1  backend has killed all in-flight ops; clear tracking state
dec0_valid  input  1  queue head (older) valid
dec0_rd / dec0_rs1 / dec0_rs2  input  REG_ABITS each  register indices
dec0_rd_en / dec0_rs1_en / dec0_rs2_en  input  1 each  register used
dec0_unit  input  2  0=ALU 1=BR 2=LSU 3=MDU
dec0_serialize  input  1  CSR/fence/system op
dec1_*  input  same set as dec0_*  second (younger) entry
dec0_ready  output  1  pop dec0 from queue
dec1_ready  output  1  pop dec1 from queue
ix0_valid  output  1  issue dec0 to pipe0
ix0_ready  input  1  pipe0 accepts
ix1_valid  output  1  issue dec1 to pipe1
ix1_ready  input  1  pipe1 accepts
wb0_valid, wb1_valid  input  1 each  one completion pulse per issued op
wb0_rd, wb1_rd  input  REG_ABITS each  completing destination
wb0_rd_en, wb1_rd_en  input  1 each  completion writes rd
sched_busy  output  1  state != RUN or in-flight count != 0

Behaviour:
- Reset (rst_n low, async): scoreboard=0, in-flight count=0, state=RUN; all outputs 0.
- Zero-latency issue: ix*/dec* outputs are combinational from inputs, registered scoreboard, count and state. No writeback bypass; a same-cycle wb clear is seen next cycle.
- hazard(x): x rs1/rs2/rd with *_en set, index != 0, and scoreboard bit set.
- ix0_valid = dec0_valid & !hazard(dec0) & count_ok & stateOK0.
  - count_ok = count + ops_issuing <= 2^CNT_W-1.
  - stateOK0: RUN and !dec0_serialize; or RUN, dec0_serialize and count==0.
- ix1_valid = ix0_valid & ix0_ready & dec1_valid & !hazard(dec1) & count_ok (for 2 ops), and:
  - dec1_unit in {ALU, BR};
  - neither entry is serialize;
  - dec0_unit != BR;
  - no intra-pair dependency: dec0 rd_en with rd != 0 matching an enabled dec1 rs1/rs2/rd.
- dec0_ready = ix0_valid & ix0_ready.
- dec1_ready = ix1_valid & ix1_ready.
- dec1_ready is never 1 while dec0_ready is 0.
- Scoreboard next state:
  - clear bit for each wb*_valid & wb*_rd_en;
  - then set bit for each fired issue with rd_en and rd != 0;
  - set wins over clear on the same index.
- Count next state = count + fired issues − wb pulses (−2..+2). Underflow is a protocol error; count saturates at 0.
- State machine:
  - RUN -> SOLO when a serialize op fires on pipe0.
  - SOLO: no issue. Leave when count reaches 0 (including the same cycle its wb arrives) -> RUN.
  - A serialize op at dec0 with count != 0 simply stalls in RUN until count==0.
- pipe_flush (synchronous, highest priority): scoreboard=0, count=0, state=RUN. No issue fires that cycle; outputs are forced 0.
- Reset asserted mid-operation clears state immediately regardless of pending wb.

Optional Feature:
- Macro: IX_SCHED_PERF_EN.
- When defined, adds three outputs, each 32 bits, incremented per clk, wrap on overflow, cleared by rst_n only (not by pipe_flush):
  - perf_dual: cycles with 2 issues;
  - perf_single: cycles with 1 issue;
  - perf_stall: cycles with dec0_valid and no issue.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Independent pair: dec0 ALU rd=5, dec1 ALU rd=6 rs1=7, all ready -> dec0_ready=dec1_ready=1 same cycle. Next cycle scoreboard bits 5,6 set, count=2.
- Intra-pair RAW: dec0 rd=5, dec1 rs1=5 -> only dec0 fires. Next cycle dec1 (now dec0) stalls until wb0 rd=5 pulse, then issues the cycle after.
- Structural: dec0 ALU, dec1 LSU -> single issue. Then LSU at head issues to pipe0 alone. ix0_ready=0 -> neither fires.
- Serialize: count=2, dec0 CSR -> stall. Two wb pulses -> CSR fires, state SOLO, sched_busy=1. Its wb -> RUN next cycle.
- Counter limit CNT_W=2: issue 3 ops with no wb -> fourth blocked. One wb -> issue resumes.
- pipe_flush with scoreboard 0x60 and count=2 -> next cycle scoreboard 0, count 0, RUN. Async rst_n mid-SOLO -> outputs 0 immediately.
